// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU definitions for the shift/rotate execution unit
// Purpose: shift op encodings, shift-unit FSM state encodings, flag bit indices
//          and a small op-legality helper shared by the shift unit files.
// Ports:   none (package).
package cpu_defs;

  localparam logic [2:0] SHOP_SLL = 3'b000;
  localparam logic [2:0] SHOP_SRL = 3'b001;
  localparam logic [2:0] SHOP_SLA = 3'b010;
  localparam logic [2:0] SHOP_SRA = 3'b011;
  localparam logic [2:0] SHOP_ROL = 3'b100;
  localparam logic [2:0] SHOP_ROR = 3'b101;

  typedef enum logic [1:0] {
    SHST_IDLE = 2'd0,
    SHST_BUSY = 2'd1,
    SHST_DONE = 2'd2
  } shst_e;

  // Bit positions inside the packed cf/zf/nf flag vector.
  localparam int CF = 0;
  localparam int ZF = 1;
  localparam int NF = 2;

  // Encodings 11x are reserved; everything else is a real shift/rotate.
  function automatic logic shop_legal(input logic [2:0] op);
    return op[2:1] != 2'b11;
  endfunction

endpackage

// File: rtl/shift_unit_step.sv
// rtl/shift_unit_step.sv - combinational multi-bit shift/rotate step with carry-out
// Purpose: shifts data by k bits (0..STEP) in the selected mode and reports the
//          last bit moved out (carry is 0 when k=0 or the mode is illegal).
// Ports:   mode  in  3        shift/rotate op encoding
//          data  in  WIDTH    value to shift
//          k     in  SHAMT_W  bits to shift this cycle, never above STEP
//          out   out WIDTH    shifted value
//          carry out 1        last bit shifted/rotated out
module shift_unit_step
  import cpu_defs::*;
#(
  parameter int WIDTH   = 16,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] k,
  output logic [WIDTH-1:0]   out,
  output logic               carry
);

  // Unrolled chain of STEP single-bit stages; stages at or beyond k pass through,
  // so carry ends up holding the bit dropped by the last active stage.
  always_comb begin
    out   = data;
    carry = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(k)) begin
        case (mode)
          SHOP_SLL: begin carry = out[WIDTH-1]; out = {out[WIDTH-2:0], 1'b0}; end
          SHOP_SRL: begin carry = out[0];       out = {1'b0, out[WIDTH-1:1]}; end
          // SLA keeps the sign bit in place and shifts only the magnitude bits.
          SHOP_SLA: begin carry = out[WIDTH-2]; out = {out[WIDTH-1], out[WIDTH-3:0], 1'b0}; end
          SHOP_SRA: begin carry = out[0];       out = {out[WIDTH-1], out[WIDTH-1:1]}; end
          SHOP_ROL: begin carry = out[WIDTH-1]; out = {out[WIDTH-2:0], out[WIDTH-1]}; end
          SHOP_ROR: begin carry = out[0];       out = {out[0], out[WIDTH-1:1]}; end
          default:  begin carry = 1'b0;         out = data; end
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_unit_iter.sv
// rtl/shift_unit_iter.sv - iterative multi-cycle shift/rotate unit for the EX stage
// Purpose: runs one shift/rotate op over ceil(shamt/STEP) cycles and publishes
//          result plus cf/zf/nf with a one-cycle done pulse.
// Ports:   clock   in  1        rising-edge clock
//          reset   in  1        synchronous, active-high
//          start   in  1        request, taken only when not busy
//          flush   in  1        abort to idle, outputs keep their values
//          op      in  3        shift/rotate mode
//          operand in  WIDTH    value to shift
//          shamt   in  SHAMT_W  shift count
//          busy    out 1        operation in flight
//          done    out 1        result/flags just updated
//          result  out WIDTH    last completed result
//          cf/zf/nf out 1       carry, zero, negative of last result
module shift_unit_iter
  import cpu_defs::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               flush,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               cf,
  output logic               zf,
  output logic               nf
);

  localparam logic [SHAMT_W-1:0] STEP_V = SHAMT_W'(STEP);

  shst_e              state, state_next;
  logic [WIDTH-1:0]   work;
  logic [2:0]         op_q;
  logic [SHAMT_W-1:0] rem, k;
  logic [WIDTH-1:0]   step_out, wb_val;
  logic               step_carry, wb_cf;
  logic               load, fast, finish;
  logic [2:0]         flags;

  assign k = (rem < STEP_V) ? rem : STEP_V;

  shift_unit_step #(
    .WIDTH  (WIDTH),
    .STEP   (STEP),
    .SHAMT_W(SHAMT_W)
  ) u_step (
    .mode (op_q),
    .data (work),
    .k    (k),
    .out  (step_out),
    .carry(step_carry)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= SHST_IDLE;
    else       state <= state_next;
  end

  // load: a request is taken; fast: it completes without iterating;
  // finish: the BUSY edge that consumes the last remaining bits.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    fast       = 1'b0;
    finish     = 1'b0;
    case (state)
      SHST_IDLE, SHST_DONE: begin
        state_next = SHST_IDLE;
        if (start) begin
          load = 1'b1;
          if (shamt == '0 || !shop_legal(op)) begin
            fast       = 1'b1;
            state_next = SHST_DONE;
          end else begin
            state_next = SHST_BUSY;
          end
        end
      end
      SHST_BUSY: begin
        if (rem <= STEP_V) begin
          finish     = 1'b1;
          state_next = SHST_DONE;
        end
      end
      default: state_next = SHST_IDLE;
    endcase
    // Flush beats everything, including a same-cycle start.
    if (flush) begin
      state_next = SHST_IDLE;
      load       = 1'b0;
      fast       = 1'b0;
      finish     = 1'b0;
    end
  end

  // Fast completions pass the operand through with no carry.
  assign wb_val = fast ? operand : step_out;
  assign wb_cf  = fast ? 1'b0    : step_carry;

  always_ff @(posedge clock) begin
    if (reset) begin
      work   <= '0;
      op_q   <= SHOP_SLL;
      rem    <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      if (load) begin
        work <= operand;
        op_q <= op;
        rem  <= shamt;
      end else if (state == SHST_BUSY) begin
        work <= step_out;
        rem  <= rem - k;
      end
      if (fast || finish) begin
        result    <= wb_val;
        flags[CF] <= wb_cf;
        flags[ZF] <= (wb_val == '0);
        flags[NF] <= wb_val[WIDTH-1];
      end
    end
  end

  assign busy = (state == SHST_BUSY);
  assign done = (state == SHST_DONE);
  assign cf   = flags[CF];
  assign zf   = flags[ZF];
  assign nf   = flags[NF];

endmodule

// File: tb/tb_shift_unit_iter.sv
// tb/tb_shift_unit_iter.sv - directed self-checking bench for shift_unit_iter
module tb_shift_unit_iter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start1, start4, flush;
  logic [2:0]  op;
  logic [15:0] operand;
  logic [3:0]  shamt;
  logic        busy1, done1, cf1, zf1, nf1;
  logic        busy4, done4, cf4, zf4, nf4;
  logic [15:0] result1, result4;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  shift_unit_iter #(.WIDTH(16), .STEP(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .flush(flush), .op(op),
    .operand(operand), .shamt(shamt), .busy(busy1), .done(done1),
    .result(result1), .cf(cf1), .zf(zf1), .nf(nf1)
  );

  shift_unit_iter #(.WIDTH(16), .STEP(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .flush(flush), .op(op),
    .operand(operand), .shamt(shamt), .busy(busy4), .done(done4),
    .result(result4), .cf(cf4), .zf(zf4), .nf(nf4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start an op in the current cycle, expect busy in cycles 1..n and done in n+1.
  task automatic go(input bit wide, input logic [2:0] o, input logic [15:0] d,
                    input logic [3:0] s, input int n, input string tag);
    op = o; operand = d; shamt = s;
    if (wide) start4 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0; start4 = 1'b0;
    for (int c = 1; c <= n; c++) begin
      chk({tag, " busy"}, wide ? busy4 : busy1, 1'b1);
      chk({tag, " early done"}, wide ? done4 : done1, 1'b0);
      tick();
    end
    chk({tag, " done"}, wide ? done4 : done1, 1'b1);
    chk({tag, " busy at done"}, wide ? busy4 : busy1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start1 = 1'b0; start4 = 1'b0; flush = 1'b0;
    op = 3'b000; operand = 16'h0000; shamt = 4'd0;
    #1;
    tick(); tick();
    reset = 1'b0;
    chk("reset busy", busy1, 1'b0);
    chk("reset done", done1, 1'b0);
    chk("reset result", result1, 16'h0000);
    chk("reset flags", {cf1, zf1, nf1}, 3'b000);
    chk("reset result4", result4, 16'h0000);

    // SLA 0x00FF by 8
    go(1'b0, 3'b010, 16'h00FF, 4'd8, 8, "sla");
    chk("sla result", result1, 16'h7F00);
    chk("sla cf/zf/nf", {cf1, zf1, nf1}, 3'b100);
    tick();
    chk("sla done one cycle", done1, 1'b0);
    chk("sla result hold", result1, 16'h7F00);

    // SRA then back-to-back SLL started in the SRA done cycle
    go(1'b0, 3'b011, 16'h8001, 4'd3, 3, "sra");
    chk("sra result", result1, 16'hF000);
    chk("sra cf/zf/nf", {cf1, zf1, nf1}, 3'b001);
    go(1'b0, 3'b000, 16'h8000, 4'd1, 1, "b2b sll");
    chk("sll result", result1, 16'h0000);
    chk("sll cf/zf/nf", {cf1, zf1, nf1}, 3'b110);

    go(1'b0, 3'b101, 16'h0001, 4'd1, 1, "ror");
    chk("ror result", result1, 16'h8000);
    chk("ror cf/zf/nf", {cf1, zf1, nf1}, 3'b101);
    go(1'b0, 3'b100, 16'h8000, 4'd1, 1, "rol");
    chk("rol result", result1, 16'h0001);
    chk("rol cf/zf/nf", {cf1, zf1, nf1}, 3'b100);

    // Zero shift amount and illegal op both complete immediately
    go(1'b0, 3'b000, 16'h8421, 4'd0, 0, "shamt0");
    chk("shamt0 result", result1, 16'h8421);
    chk("shamt0 cf/zf/nf", {cf1, zf1, nf1}, 3'b001);
    go(1'b0, 3'b110, 16'h1234, 4'd5, 0, "illegal");
    chk("illegal result", result1, 16'h1234);
    chk("illegal cf/zf/nf", {cf1, zf1, nf1}, 3'b000);
    tick();

    // STEP=4: SRL 0xFFFF by 15 takes 4 iterations
    go(1'b1, 3'b001, 16'hFFFF, 4'd15, 4, "srl4");
    chk("srl4 result", result4, 16'h0001);
    chk("srl4 cf/zf/nf", {cf4, zf4, nf4}, 3'b100);
    tick();

    // Flush mid-operation; a start in cycle 2 must be ignored
    op = 3'b000; operand = 16'h00FF; shamt = 4'd8; start1 = 1'b1;
    tick();                                    // cycle 1
    start1 = 1'b0;
    chk("flush busy c1", busy1, 1'b1);
    tick();                                    // cycle 2
    start1 = 1'b1; op = 3'b001; operand = 16'hAAAA; shamt = 4'd1;
    tick();                                    // cycle 3
    start1 = 1'b0; flush = 1'b1;
    chk("flush busy c3", busy1, 1'b1);
    tick();                                    // cycle 4
    flush = 1'b0;
    chk("flush busy c4", busy1, 1'b0);
    chk("flush no done", done1, 1'b0);
    chk("flush result kept", result1, 16'h1234);
    chk("flush flags kept", {cf1, zf1, nf1}, 3'b000);
    for (int c = 0; c < 10; c++) begin
      chk("flush no late done", {busy1, done1}, 2'b00);
      tick();
    end

    // Flush and start together: the start is dropped
    op = 3'b000; operand = 16'h0003; shamt = 4'd0; start1 = 1'b1; flush = 1'b1;
    tick();
    start1 = 1'b0; flush = 1'b0;
    chk("flush+start done", done1, 1'b0);
    chk("flush+start busy", busy1, 1'b0);
    chk("flush+start result", result1, 16'h1234);

    // Reset in mid-BUSY clears everything
    op = 3'b100; operand = 16'h00F0; shamt = 4'd8; start1 = 1'b1; start4 = 1'b1;
    tick();
    start1 = 1'b0; start4 = 1'b0;
    tick(); tick();
    chk("pre-reset busy", busy1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset busy", busy1, 1'b0);
    chk("midreset done", done1, 1'b0);
    chk("midreset result", result1, 16'h0000);
    chk("midreset flags", {cf1, zf1, nf1}, 3'b000);
    chk("midreset result4", {busy4, done4, result4}, 18'h0);

    // Recovery after reset
    go(1'b0, 3'b001, 16'h0006, 4'd2, 2, "post srl");
    chk("post srl result", result1, 16'h0001);
    chk("post srl cf/zf/nf", {cf1, zf1, nf1}, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
